// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 key events to ZX Spectrum 8x5 keyboard matrix, answering port 0xFE reads.
// One flag per physical source, so compound keys only OR into the matrix and never touch real shift flags.
module ps2_keymatrix (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       strb_i,
  input  logic       make_i,
  input  logic [7:0] code_i,
  input  logic [7:0] row_i,
  output logic [4:0] cols_o,
  output logic       anykey_o
);

  // Compound source flag indices
  localparam int LSH = 0;
  localparam int RSH = 1;
  localparam int CTL = 2;
  localparam int BKS = 3;
  localparam int LFT = 4;
  localparam int DWN = 5;
  localparam int UP  = 6;
  localparam int RGT = 7;
  localparam int ESC = 8;

  // Direct flags indexed row*5+col; positions 0 (CS) and 36 (SS) have no direct key and stay 0
  logic [39:0] dir_q, dir_d;
  logic [8:0]  cmp_q, cmp_d;
  logic [39:0] mat;
  logic [4:0]  sel;
  logic [4:0]  cols_q;
  logic        any_q;

  always_comb begin
    dir_d = dir_q;
    cmp_d = cmp_q;
    if (strb_i) begin
      case (code_i)
        8'h1A: dir_d[1]  = make_i;
        8'h22: dir_d[2]  = make_i;
        8'h21: dir_d[3]  = make_i;
        8'h2A: dir_d[4]  = make_i;
        8'h1C: dir_d[5]  = make_i;
        8'h1B: dir_d[6]  = make_i;
        8'h23: dir_d[7]  = make_i;
        8'h2B: dir_d[8]  = make_i;
        8'h34: dir_d[9]  = make_i;
        8'h15: dir_d[10] = make_i;
        8'h1D: dir_d[11] = make_i;
        8'h24: dir_d[12] = make_i;
        8'h2D: dir_d[13] = make_i;
        8'h2C: dir_d[14] = make_i;
        8'h16: dir_d[15] = make_i;
        8'h1E: dir_d[16] = make_i;
        8'h26: dir_d[17] = make_i;
        8'h25: dir_d[18] = make_i;
        8'h2E: dir_d[19] = make_i;
        8'h45: dir_d[20] = make_i;
        8'h46: dir_d[21] = make_i;
        8'h3E: dir_d[22] = make_i;
        8'h3D: dir_d[23] = make_i;
        8'h36: dir_d[24] = make_i;
        8'h4D: dir_d[25] = make_i;
        8'h44: dir_d[26] = make_i;
        8'h43: dir_d[27] = make_i;
        8'h3C: dir_d[28] = make_i;
        8'h35: dir_d[29] = make_i;
        8'h5A: dir_d[30] = make_i;
        8'h4B: dir_d[31] = make_i;
        8'h42: dir_d[32] = make_i;
        8'h3B: dir_d[33] = make_i;
        8'h33: dir_d[34] = make_i;
        8'h29: dir_d[35] = make_i;
        8'h3A: dir_d[37] = make_i;
        8'h31: dir_d[38] = make_i;
        8'h32: dir_d[39] = make_i;
        8'h12: cmp_d[LSH] = make_i;
        8'h59: cmp_d[RSH] = make_i;
        8'h14: cmp_d[CTL] = make_i;
        8'h66: cmp_d[BKS] = make_i;
        8'h6B: cmp_d[LFT] = make_i;
        8'h72: cmp_d[DWN] = make_i;
        8'h75: cmp_d[UP]  = make_i;
        8'h74: cmp_d[RGT] = make_i;
        8'h76: cmp_d[ESC] = make_i;
        default: ;
      endcase
    end
  end

  // Compound keys: CS plus a digit (0,5,6,7,8) or Space
  always_comb begin
    mat     = dir_q;
    mat[0]  = dir_q[0] | (|{cmp_q[LSH], cmp_q[RSH], cmp_q[BKS], cmp_q[LFT],
                            cmp_q[DWN], cmp_q[UP], cmp_q[RGT], cmp_q[ESC]});
    mat[36] = dir_q[36] | cmp_q[CTL];
    mat[20] = dir_q[20] | cmp_q[BKS];
    mat[19] = dir_q[19] | cmp_q[LFT];
    mat[24] = dir_q[24] | cmp_q[DWN];
    mat[23] = dir_q[23] | cmp_q[UP];
    mat[22] = dir_q[22] | cmp_q[RGT];
    mat[35] = dir_q[35] | cmp_q[ESC];
  end

  always_comb begin
    sel = 5'b00000;
    for (int r = 0; r < 8; r++) begin
      if (!row_i[r]) sel = sel | mat[r*5 +: 5];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      dir_q  <= '0;
      cmp_q  <= '0;
      cols_q <= 5'b11111;
      any_q  <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      cmp_q  <= cmp_d;
      cols_q <= ~sel;
      any_q  <= |mat;
    end
  end

  assign cols_o   = cols_q;
  assign anykey_o = any_q;

endmodule
